mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 73 +++++++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage_load_extend.sv | 26 ++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, opcode enumeration,
// access-length encodings and small opcode classification helpers.
package mem_stage_pkg;

  localparam int MS_OPT_W  = 6;
  localparam int MS_REG_AW = 5;
  localparam int MS_XLEN   = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // mc_len carries (bytes - 1)
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [MS_OPT_W-1:0] {
    ZERO_OPT = 6'd0,
    OPT_ADD  = 6'd1,
    OPT_ADDI = 6'd2,
    OPT_SUB  = 6'd3,
    OPT_AND  = 6'd4,
    OPT_OR   = 6'd5,
    OPT_XOR  = 6'd6,
    OPT_SLL  = 6'd7,
    OPT_LUI  = 6'd8,
    OPT_LB   = 6'd16,
    OPT_LH   = 6'd17,
    OPT_LW   = 6'd18,
    OPT_LBU  = 6'd19,
    OPT_LHU  = 6'd20,
    OPT_SB   = 6'd24,
    OPT_SH   = 6'd25,
    OPT_SW   = 6'd26
  } opt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [MS_OPT_W-1:0] op);
    case (op)
      OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU: is_load = 1'b1;
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [MS_OPT_W-1:0] op);
    case (op)
      OPT_SB, OPT_SH, OPT_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] access_len(input logic [MS_OPT_W-1:0] op);
    case (op)
      OPT_LB, OPT_LBU, OPT_SB: access_len = LEN_BYTE;
      OPT_LH, OPT_LHU, OPT_SH: access_len = LEN_HALF;
      default:                 access_len = LEN_WORD;
    endcase
  endfunction

  function automatic logic [MS_XLEN-1:0] store_mask(input logic [1:0] len);
    case (len)
      LEN_BYTE: store_mask = 32'h0000_00FF;
      LEN_HALF: store_mask = 32'h0000_FFFF;
      default:  store_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/done bus between the memory stage (master) and the memory
// controller (slave); data is LSB-aligned in both directions.
interface mem_stage_if #(
  parameter int XLEN = mem_stage_pkg::MS_XLEN
);

  logic            mc_req;
  logic            mc_we;
  logic [XLEN-1:0] mc_addr;
  logic [1:0]      mc_len;
  logic [XLEN-1:0] mc_wdata;
  logic            mc_done;
  logic [XLEN-1:0] mc_rdata;

  modport master (
    output mc_req, mc_we, mc_addr, mc_len, mc_wdata,
    input  mc_done, mc_rdata
  );

  modport slave (
    input  mc_req, mc_we, mc_addr, mc_len, mc_wdata,
    output mc_done, mc_rdata
  );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Load-data extension: picks the byte/half/word of the raw LSB-aligned
// controller data and sign- or zero-extends it according to the opcode.
module mem_stage_load_extend
  import mem_stage_pkg::*;
#(
  parameter int OPT_W = MS_OPT_W,
  parameter int XLEN  = MS_XLEN
) (
  input  logic [OPT_W-1:0] op,
  input  logic [XLEN-1:0]  raw,
  output logic [XLEN-1:0]  ext
);

  // Width selection and extension of the returned load data
  always_comb begin
    ext = raw;
    case (op)
      OPT_LB:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      OPT_LBU: ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      OPT_LH:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      OPT_LHU: ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers ALU results toward write-back and runs
// loads/stores through the memory controller, stalling upstream meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int OPT_W  = MS_OPT_W,
  parameter int REG_AW = MS_REG_AW,
  parameter int XLEN   = MS_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [OPT_W-1:0]  inst_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   vd_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic              w_enable_i,
  mem_stage_if.master       mc,
  output logic              stall_req,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   vd_o,
  output logic              w_enable_o
);

  mem_state_e        state_r, state_nxt_s;
  logic [OPT_W-1:0]  op_r, op_nxt_s;
  logic [REG_AW-1:0] rd_mem_r, rd_mem_nxt_s;
  logic [REG_AW-1:0] rd_r, rd_nxt_s;
  logic [XLEN-1:0]   vd_r, vd_nxt_s;
  logic              we_r, we_nxt_s;
  logic              req_r, req_nxt_s;
  logic              mwe_r, mwe_nxt_s;
  logic [XLEN-1:0]   addr_r, addr_nxt_s;
  logic [XLEN-1:0]   wdata_r, wdata_nxt_s;
  logic [1:0]        len_r, len_nxt_s;
  logic              stall_s;
  logic              is_mem_s;
  logic              rd_nz_s;
  logic              rd_mem_nz_s;
  logic [XLEN-1:0]   ext_s;

  assign is_mem_s    = is_load(inst_i) | is_store(inst_i);
  assign rd_nz_s     = (rd_i != {REG_AW{1'b0}});
  assign rd_mem_nz_s = (rd_mem_r != {REG_AW{1'b0}});

  // Extension uses the opcode captured at request time
  mem_stage_load_extend #(
    .OPT_W (OPT_W),
    .XLEN  (XLEN)
  ) u_load_extend (
    .op  (op_r),
    .raw (mc.mc_rdata),
    .ext (ext_s)
  );

  // Next-state, next-register values and the combinational stall request
  always_comb begin
    state_nxt_s  = state_r;
    op_nxt_s     = op_r;
    rd_mem_nxt_s = rd_mem_r;
    rd_nxt_s     = rd_r;
    vd_nxt_s     = vd_r;
    we_nxt_s     = we_r;
    req_nxt_s    = req_r;
    mwe_nxt_s    = mwe_r;
    addr_nxt_s   = addr_r;
    wdata_nxt_s  = wdata_r;
    len_nxt_s    = len_r;
    stall_s      = DISABLE;

    case (state_r)
      ST_IDLE: begin
        if (is_mem_s) begin
          stall_s      = ENABLE;
          state_nxt_s  = ST_REQ;
          we_nxt_s     = DISABLE;
          req_nxt_s    = ENABLE;
          mwe_nxt_s    = is_store(inst_i);
          addr_nxt_s   = addr_i;
          len_nxt_s    = access_len(inst_i);
          wdata_nxt_s  = vd_i & store_mask(access_len(inst_i));
          op_nxt_s     = inst_i;
          rd_mem_nxt_s = rd_i;
        end else begin
          rd_nxt_s = rd_i;
          vd_nxt_s = vd_i;
          we_nxt_s = w_enable_i & rd_nz_s & (inst_i != ZERO_OPT);
        end
      end
      ST_REQ: begin
        stall_s     = ENABLE;
        req_nxt_s   = DISABLE;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        stall_s   = ENABLE;
        req_nxt_s = DISABLE;
        if (mc.mc_done) begin
          state_nxt_s = ST_IDLE;
          rd_nxt_s    = rd_mem_r;
          if (is_store(op_r)) begin
            vd_nxt_s = {XLEN{1'b0}};
            we_nxt_s = DISABLE;
          end else begin
            vd_nxt_s = ext_s;
            we_nxt_s = rd_mem_nz_s;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        req_nxt_s   = DISABLE;
        we_nxt_s    = DISABLE;
      end
    endcase
  end

  // FSM state register; rdy low freezes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else if (rdy) begin
      state_r <= state_nxt_s;
    end
  end

  // Result, controller-bus and captured-instruction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r     <= {OPT_W{1'b0}};
      rd_mem_r <= {REG_AW{1'b0}};
      rd_r     <= {REG_AW{1'b0}};
      vd_r     <= {XLEN{1'b0}};
      we_r     <= 1'b0;
      req_r    <= 1'b0;
      mwe_r    <= 1'b0;
      addr_r   <= {XLEN{1'b0}};
      wdata_r  <= {XLEN{1'b0}};
      len_r    <= 2'd0;
    end else if (rdy) begin
      op_r     <= op_nxt_s;
      rd_mem_r <= rd_mem_nxt_s;
      rd_r     <= rd_nxt_s;
      vd_r     <= vd_nxt_s;
      we_r     <= we_nxt_s;
      req_r    <= req_nxt_s;
      mwe_r    <= mwe_nxt_s;
      addr_r   <= addr_nxt_s;
      wdata_r  <= wdata_nxt_s;
      len_r    <= len_nxt_s;
    end
  end

  // Stall must read 0 while reset is held, even with a load still presented
  assign stall_req   = stall_s & rst;
  assign rd_o        = rd_r;
  assign vd_o        = vd_r;
  assign w_enable_o  = we_r;
  assign mc.mc_req   = req_r;
  assign mc.mc_we    = mwe_r;
  assign mc.mc_addr  = addr_r;
  assign mc.mc_len   = len_r;
  assign mc.mc_wdata = wdata_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, randomized traffic
// against an arithmetic reference model, and hand-written rdy/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  inst_i;
  logic [4:0]  rd_i;
  logic [31:0] vd_i;
  logic [31:0] addr_i;
  logic        w_enable_i;
  logic        stall_req;
  logic [4:0]  rd_o;
  logic [31:0] vd_o;
  logic        w_enable_o;

  logic [5:0]  le_op;
  logic [31:0] le_raw;
  logic [31:0] le_ext;

  int n_pass  = 0;
  int n_total = 0;

  mem_stage_if mc ();

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .inst_i     (inst_i),
    .rd_i       (rd_i),
    .vd_i       (vd_i),
    .addr_i     (addr_i),
    .w_enable_i (w_enable_i),
    .mc         (mc),
    .stall_req  (stall_req),
    .rd_o       (rd_o),
    .vd_o       (vd_o),
    .w_enable_o (w_enable_o)
  );

  mem_stage_load_extend u_wb_ext (
    .op  (le_op),
    .raw (le_raw),
    .ext (le_ext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] vd;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          lat;      // 0 = ALU/bubble, else WAIT cycles until done
    logic        we_in;
    logic [31:0] exp_vd;
    logic        exp_we;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: arithmetic on byte/half values, independent of bit slicing
  function automatic logic [31:0] m_ext(input logic [5:0] op, input logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = raw % 32'd256;
    h = raw % 32'd65536;
    case (op)
      OPT_LB:  m_ext = (b >= 32'd128)   ? b - 32'd256   : b;
      OPT_LBU: m_ext = b;
      OPT_LH:  m_ext = (h >= 32'd32768) ? h - 32'd65536 : h;
      OPT_LHU: m_ext = h;
      default: m_ext = raw;
    endcase
  endfunction

  function automatic int m_bytes(input logic [5:0] op);
    case (op)
      OPT_LB, OPT_LBU, OPT_SB: m_bytes = 1;
      OPT_LH, OPT_LHU, OPT_SH: m_bytes = 2;
      default:                 m_bytes = 4;
    endcase
  endfunction

  function automatic logic m_store(input logic [5:0] op);
    m_store = (op == OPT_SB) || (op == OPT_SH) || (op == OPT_SW);
  endfunction

  function automatic logic m_mem(input logic [5:0] op);
    m_mem = m_store(op) || (op == OPT_LB) || (op == OPT_LH) || (op == OPT_LW) ||
            (op == OPT_LBU) || (op == OPT_LHU);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] vd);
    case (m_bytes(op))
      1:       m_wdata = vd % 32'd256;
      2:       m_wdata = vd % 32'd65536;
      default: m_wdata = vd;
    endcase
  endfunction

  // Entered shortly after a rising edge with the stage in IDLE
  task automatic run_alu(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] vd,
                         input logic we_in, input logic [31:0] exp_vd, input logic exp_we,
                         input string tag);
    inst_i = op; rd_i = rd; vd_i = vd; addr_i = $urandom; w_enable_i = we_in;
    #1 chk({tag, " alu_stall"}, 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    chk({tag, " alu_rd"}, 32'(rd_o), 32'(rd));
    chk({tag, " alu_vd"}, vd_o, exp_vd);
    chk({tag, " alu_we"}, 32'(w_enable_o), 32'(exp_we));
  endtask

  task automatic run_mem(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] vd,
                         input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                         input logic spur, input logic [31:0] exp_vd, input logic exp_we,
                         input string tag);
    int sc;
    inst_i = op; rd_i = rd; vd_i = vd; addr_i = addr; w_enable_i = 1'b1;
    #1 chk({tag, " idle_stall"}, 32'(stall_req), 32'd1);
    sc = 1;
    @(posedge clk); #1;
    chk({tag, " req"}, 32'(mc.mc_req), 32'd1);
    chk({tag, " we"}, 32'(mc.mc_we), 32'(m_store(op)));
    chk({tag, " addr"}, mc.mc_addr, addr);
    chk({tag, " len"}, 32'(mc.mc_len), 32'(m_bytes(op) - 1));
    if (m_store(op)) chk({tag, " wdata"}, mc.mc_wdata, m_wdata(op, vd));
    chk({tag, " we_cleared"}, 32'(w_enable_o), 32'd0);
    if (spur) begin
      mc.mc_done = 1'b1; mc.mc_rdata = 32'hAAAA_AAAA;
    end
    #1 sc += int'(stall_req);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      mc.mc_done = 1'b0;
      chk({tag, " wait_req"}, 32'(mc.mc_req), 32'd0);
      if (i == lat) begin
        mc.mc_done = 1'b1; mc.mc_rdata = rdata;
      end
      #1 sc += int'(stall_req);
    end
    @(posedge clk); #1;
    mc.mc_done = 1'b0; inst_i = ZERO_OPT; w_enable_i = 1'b0;
    chk({tag, " res_rd"}, 32'(rd_o), 32'(rd));
    chk({tag, " res_vd"}, vd_o, exp_vd);
    chk({tag, " res_we"}, 32'(w_enable_o), 32'(exp_we));
    #1 chk({tag, " stall_drop"}, 32'(stall_req), 32'd0);
    chk({tag, " stall_cycles"}, 32'(sc), 32'(2 + lat));
  endtask

  initial begin
    logic [5:0]  ops[12];
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] vd, addr, rdata, ev;
    logic        we_in, spur, ew;
    int          lat;

    ops = '{OPT_ADD, OPT_ADDI, OPT_SUB, ZERO_OPT, OPT_LB, OPT_LH, OPT_LW,
            OPT_LBU, OPT_LHU, OPT_SB, OPT_SH, OPT_SW};

    tbl[0]  = '{OPT_ADD,  5'd5,  32'h0000_0123, 32'h0,      32'h0,         0, 1'b1, 32'h0000_0123, 1'b1};
    tbl[1]  = '{OPT_LB,   5'd6,  32'h0,         32'h1000,   32'h0000_0080, 2, 1'b1, 32'hFFFF_FF80, 1'b1};
    tbl[2]  = '{OPT_LBU,  5'd6,  32'h0,         32'h1000,   32'h0000_0080, 2, 1'b1, 32'h0000_0080, 1'b1};
    tbl[3]  = '{OPT_SH,   5'd9,  32'hDEAD_BEEF, 32'h2002,   32'h0,         1, 1'b1, 32'h0,         1'b0};
    tbl[4]  = '{OPT_LW,   5'd0,  32'h0,         32'h0400,   32'h1234_5678, 1, 1'b1, 32'h1234_5678, 1'b0};
    tbl[5]  = '{OPT_LH,   5'd10, 32'h0,         32'h0013,   32'h0000_8001, 3, 1'b1, 32'hFFFF_8001, 1'b1};
    tbl[6]  = '{OPT_LHU,  5'd11, 32'h0,         32'h0020,   32'hFFFF_7FFE, 1, 1'b1, 32'h0000_7FFE, 1'b1};
    tbl[7]  = '{OPT_SB,   5'd12, 32'h1234_56A5, 32'h0031,   32'h0,         2, 1'b1, 32'h0,         1'b0};
    tbl[8]  = '{OPT_SW,   5'd13, 32'hCAFE_F00D, 32'h0040,   32'h0,         1, 1'b1, 32'h0,         1'b0};
    tbl[9]  = '{OPT_ADD,  5'd0,  32'h0000_0055, 32'h0,      32'h0,         0, 1'b1, 32'h0000_0055, 1'b0};
    tbl[10] = '{ZERO_OPT, 5'd3,  32'h0000_0077, 32'h0,      32'h0,         0, 1'b1, 32'h0000_0077, 1'b0};
    tbl[11] = '{OPT_ADDI, 5'd31, 32'hFFFF_FFFF, 32'h0,      32'h0,         0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tbl[12] = '{OPT_LB,   5'd1,  32'h0,         32'h0051,   32'h0000_007F, 1, 1'b1, 32'h0000_007F, 1'b1};

    rst = 1'b0; rdy = 1'b1; inst_i = ZERO_OPT; rd_i = 5'd0; vd_i = 32'd0; addr_i = 32'd0;
    w_enable_i = 1'b0; mc.mc_done = 1'b0; mc.mc_rdata = 32'd0; le_op = ZERO_OPT; le_raw = 32'd0;
    #12;
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_vd", vd_o, 32'd0);
    chk("rst_we", 32'(w_enable_o), 32'd0);
    chk("rst_req", 32'(mc.mc_req), 32'd0);
    chk("rst_addr", mc.mc_addr, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].lat == 0)
        run_alu(tbl[i].op, tbl[i].rd, tbl[i].vd, tbl[i].we_in, tbl[i].exp_vd, tbl[i].exp_we,
                $sformatf("tbl%0d", i));
      else
        run_mem(tbl[i].op, tbl[i].rd, tbl[i].vd, tbl[i].addr, tbl[i].rdata, tbl[i].lat, 1'b0,
                tbl[i].exp_vd, tbl[i].exp_we, $sformatf("tbl%0d", i));
    end

    // Spurious done while idle with an ALU op
    mc.mc_done = 1'b1; mc.mc_rdata = 32'hFFFF_0000;
    run_alu(OPT_ADD, 5'd4, 32'h0000_0099, 1'b1, 32'h0000_0099, 1'b1, "spur_idle");
    mc.mc_done = 1'b0;

    for (int n = 0; n < 150; n++) begin
      op    = ops[$urandom_range(0, 11)];
      rd    = 5'($urandom_range(0, 31));
      vd    = $urandom;
      addr  = $urandom;
      rdata = $urandom;
      lat   = $urandom_range(1, 4);
      spur  = ($urandom_range(0, 9) == 0);
      we_in = 1'($urandom_range(0, 1));
      le_op = op; le_raw = rdata;
      #1 chk($sformatf("rnd%0d wb_ext", n), le_ext, m_ext(op, rdata));
      if (m_mem(op)) begin
        ev = m_store(op) ? 32'd0 : m_ext(op, rdata);
        ew = !m_store(op) && (rd != 5'd0);
        run_mem(op, rd, vd, addr, rdata, lat, spur, ev, ew, $sformatf("rnd%0d", n));
      end else begin
        ew = we_in && (rd != 5'd0) && (op != ZERO_OPT);
        run_alu(op, rd, vd, we_in, vd, ew, $sformatf("rnd%0d", n));
      end
    end

    // rdy low in REQ and for 3 cycles in WAIT, then normal completion
    inst_i = OPT_LW; rd_i = 5'd14; vd_i = 32'd0; addr_i = 32'h0000_3000; w_enable_i = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    @(posedge clk); #1;
    chk("frz_req_held", 32'(mc.mc_req), 32'd1);
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("frz_req_off", 32'(mc.mc_req), 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("frz_stall", 32'(stall_req), 32'd1);
      chk("frz_req", 32'(mc.mc_req), 32'd0);
      chk("frz_addr", mc.mc_addr, 32'h0000_3000);
      chk("frz_len", 32'(mc.mc_len), 32'd3);
      chk("frz_we", 32'(w_enable_o), 32'd0);
    end
    rdy = 1'b1; mc.mc_done = 1'b1; mc.mc_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    mc.mc_done = 1'b0; inst_i = ZERO_OPT; w_enable_i = 1'b0;
    chk("frz_res_vd", vd_o, 32'h8765_4321);
    chk("frz_res_we", 32'(w_enable_o), 32'd1);
    chk("frz_res_rd", 32'(rd_o), 32'd14);
    #1 chk("frz_stall_drop", 32'(stall_req), 32'd0);

    // Asynchronous reset in WAIT, then a stale done and a 1-cycle ADDI
    inst_i = OPT_LW; rd_i = 5'd15; vd_i = 32'd0; addr_i = 32'h0000_4000; w_enable_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_rd", 32'(rd_o), 32'd0);
    chk("arst_vd", vd_o, 32'd0);
    chk("arst_addr", mc.mc_addr, 32'd0);
    chk("arst_len", 32'(mc.mc_len), 32'd0);
    chk("arst_mwe", 32'(mc.mc_we), 32'd0);
    chk("arst_stall", 32'(stall_req), 32'd0);
    inst_i = ZERO_OPT; w_enable_i = 1'b0; vd_i = 32'd0;
    #1 rst = 1'b1;
    mc.mc_done = 1'b1; mc.mc_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mc.mc_done = 1'b0;
    chk("stale_done_we", 32'(w_enable_o), 32'd0);
    chk("stale_done_vd", vd_o, 32'd0);
    chk("stale_done_stall", 32'(stall_req), 32'd0);
    run_alu(OPT_ADDI, 5'd7, 32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
